slavefifo2b_bus_ctrl: RTL and testbench
=======================================

Name: slavefifo2b_bus_ctrl

Overview:
- Output stage between the slave-FIFO mode generators (stream, partial, ZLP) and the FX3 GPIF-II slave-FIFO pins.
- Registers the raw FX3 flags to produce flaga_d/flagb_d for the generators, and owns mode selection with a safe drain interval between modes.
- Muxes the active generator's strobes and data onto registered FX3 outputs, and counts words and packets written.

Parameters:
- DATA_W, 32, width of the FX3 data bus and of the generator data inputs
- STABLE_CYCLES, 16, cycles the synchronized mode_sel must hold one value before a change is accepted
- DRAIN_CYCLES, 32, idle cycles with all mode_selected outputs low before a new mode is enabled
- PKT_CNT_W, 16, width of the packet counter

Ports:
- clk_100, in, 1, 100 MHz system clock
- reset, in, 1, asynchronous, active-high reset
- mode_sel, in, 2, requested mode from switches/host (asynchronous): 0 none, 1 stream, 2 partial, 3 ZLP
- flaga, in, 1, raw FX3 FLAGA (DMA ready)
- flagb, in, 1, raw FX3 FLAGB (watermark)
- slwr_stream_, in, 1, stream generator write strobe, active low
- pktend_stream_, in, 1, stream generator packet end, active low
- data_stream, in, DATA_W, stream generator data
- slwr_partial_, in, 1, partial generator write strobe, active low
- pktend_partial_, in, 1, partial generator packet end, active low
- data_partial, in, DATA_W, partial generator data
- slwr_zlp_, in, 1, ZLP generator write strobe, active low
- pktend_zlp_, in, 1, ZLP generator packet end, active low
- data_out_zlp, in, DATA_W, ZLP generator data
- flaga_d, out, 1, FLAGA registered once
- flagb_d, out, 1, FLAGB registered once
- stream_mode_selected, out, 1, enables the stream generator
- partial_mode_selected, out, 1, enables the partial generator
- zlp_mode_selected, out, 1, enables the ZLP generator
- slcs_, out, 1, FX3 chip select, active low
- slwr_, out, 1, FX3 write strobe, active low
- slrd_, out, 1, FX3 read strobe, held high
- sloe_, out, 1, FX3 output enable, held high
- pktend_, out, 1, FX3 packet end, active low
- fifo_addr, out, 2, FX3 socket address, fixed 2'b00
- fdata, out, DATA_W, FX3 data bus drive value
- fdata_oe, out, 1, tristate enable for fdata
- active_mode, out, 2, mode currently granted
- wr_word_cnt, out, 32, count of words written
- pkt_cnt, out, PKT_CNT_W, count of packets ended

Behaviour:
- Reset values: slwr_, pktend_, slrd_, sloe_ = 1; slcs_ = 1; fdata = 0; fdata_oe = 0; all mode_selected = 0; active_mode = 0; counters = 0; flaga_d = flagb_d = 0.
- Reset asserted mid-operation forces these values immediately; no partial packet is completed.
- Flags: flaga_d and flagb_d are single flops on flaga and flagb, giving 1 cycle of latency.
- Mode input: mode_sel passes through a 2-flop synchronizer.
- A stability counter clears whenever the synchronized value changes. The value becomes req_mode once it has held for STABLE_CYCLES consecutive cycles.
- State machine:
  - S_IDLE: all mode_selected = 0; slcs_ = 1. If req_mode != 0, go to S_ACTIVE with active_mode = req_mode.
  - S_ACTIVE: exactly the one mode_selected output matching active_mode is 1; slcs_ = 0; fdata_oe = 1. If req_mode != active_mode, go to S_DRAIN.
  - S_DRAIN: all mode_selected = 0. The drain counter clears on any cycle where a muxed generator slwr_ or pktend_ is low, and otherwise increments. At DRAIN_CYCLES, set active_mode = req_mode and go to S_ACTIVE, or go to S_IDLE if req_mode = 0.
- If req_mode changes again during S_DRAIN, the latest value is used at drain exit and the drain is not restarted.
- Output mux: select the generator given by active_mode, in S_ACTIVE and S_DRAIN only.
  - slwr_, pktend_ and fdata are registered, so a generator strobe reaches the pins 1 cycle later.
  - In S_IDLE, or when active_mode = 0, the muxed strobes are 1.
- Gating: strobes from non-selected generators are ignored in every state.
- Simultaneous slwr_ low and pktend_ low are passed through unchanged; this is a short packet.
- pktend_ low with slwr_ high is passed as a ZLP.
- wr_word_cnt increments on each cycle the registered slwr_ = 0 and wraps at 2^32.
- pkt_cnt increments on each cycle the registered pktend_ = 0, ZLPs included, and wraps.
- fdata_oe stays 1 through S_DRAIN and goes to 0 on the cycle S_IDLE is entered.

Test Plan:
- Reset, then mode_sel=3 held -> zlp_mode_selected=1 at 2 + STABLE_CYCLES + 1 cycles (19); slcs_=0, fdata_oe=1, active_mode=3.
- Mode 3 active; ZLP generator pulls slwr_zlp_ low for 4 cycles with data 0..3 -> slwr_ low 4 cycles starting 1 cycle later, fdata=0,1,2,3, wr_word_cnt=4.
- Mode 3 active; pktend_zlp_ low 1 cycle with slwr_zlp_ high -> pktend_ low 1 cycle after, slwr_ stays 1, pkt_cnt=1.
- Glitch mode_sel 3->1 for 5 cycles then back -> no state change, zlp_mode_selected stays 1.
- Switch mode_sel 3->1 while the ZLP generator is still writing -> zlp_mode_selected=0 immediately; drain holds until generator strobes stay high 32 cycles; then stream_mode_selected=1; no stream strobe is passed during S_DRAIN.
- Assert reset while slwr_=0 mid-burst -> slwr_=1, pktend_=1, counters=0, fdata_oe=0 in the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/slavefifo2b_bus_ctrl_if.sv
// Bundle of slave-FIFO signals around slavefifo2b_bus_ctrl.
//   Generator side : per-mode write strobe, packet end and data (stream, partial, ZLP),
//                    plus the mode_sel request and the raw FX3 flags.
//   FX3 side       : slcs_/slwr_/slrd_/sloe_/pktend_/fifo_addr/fdata/fdata_oe.
//   Status         : registered flags, per-mode enables, active_mode and traffic counters.
// The controller connects through the master modport; the environment uses slave.
interface slavefifo2b_bus_ctrl_if #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PKT_CNT_W = 16
);
  logic [1:0]           mode_sel;
  logic                 flaga;
  logic                 flagb;
  logic                 slwr_stream_;
  logic                 pktend_stream_;
  logic [DATA_W-1:0]    data_stream;
  logic                 slwr_partial_;
  logic                 pktend_partial_;
  logic [DATA_W-1:0]    data_partial;
  logic                 slwr_zlp_;
  logic                 pktend_zlp_;
  logic [DATA_W-1:0]    data_out_zlp;

  logic                 flaga_d;
  logic                 flagb_d;
  logic                 stream_mode_selected;
  logic                 partial_mode_selected;
  logic                 zlp_mode_selected;
  logic                 slcs_;
  logic                 slwr_;
  logic                 slrd_;
  logic                 sloe_;
  logic                 pktend_;
  logic [1:0]           fifo_addr;
  logic [DATA_W-1:0]    fdata;
  logic                 fdata_oe;
  logic [1:0]           active_mode;
  logic [31:0]          wr_word_cnt;
  logic [PKT_CNT_W-1:0] pkt_cnt;

  modport master (
    input  mode_sel, flaga, flagb,
    input  slwr_stream_, pktend_stream_, data_stream,
    input  slwr_partial_, pktend_partial_, data_partial,
    input  slwr_zlp_, pktend_zlp_, data_out_zlp,
    output flaga_d, flagb_d,
    output stream_mode_selected, partial_mode_selected, zlp_mode_selected,
    output slcs_, slwr_, slrd_, sloe_, pktend_, fifo_addr, fdata, fdata_oe,
    output active_mode, wr_word_cnt, pkt_cnt
  );

  modport slave (
    output mode_sel, flaga, flagb,
    output slwr_stream_, pktend_stream_, data_stream,
    output slwr_partial_, pktend_partial_, data_partial,
    output slwr_zlp_, pktend_zlp_, data_out_zlp,
    input  flaga_d, flagb_d,
    input  stream_mode_selected, partial_mode_selected, zlp_mode_selected,
    input  slcs_, slwr_, slrd_, sloe_, pktend_, fifo_addr, fdata, fdata_oe,
    input  active_mode, wr_word_cnt, pkt_cnt
  );
endinterface

// File: rtl/slavefifo2b_bus_ctrl.sv
// Output stage between the slave-FIFO mode generators and the FX3 GPIF-II pins.
//   clk_100 : system clock
//   reset   : asynchronous, active-high reset
//   bus     : slavefifo2b_bus_ctrl_if master view (generator inputs, FX3 outputs, status)
// Registers the FX3 flags, debounces mode_sel into a granted mode with a drain interval
// between modes, muxes the granted generator onto registered FX3 pins and counts traffic.
module slavefifo2b_bus_ctrl #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned DRAIN_CYCLES  = 32,
  parameter int unsigned PKT_CNT_W     = 16
) (
  input logic                    clk_100,
  input logic                    reset,
  slavefifo2b_bus_ctrl_if.master bus
);

  localparam int unsigned StabW  = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned DrainW = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StActive, StDrain} state_e;

  // Flags
  logic flaga_q, flagb_q;

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      flaga_q <= 1'b0;
      flagb_q <= 1'b0;
    end else begin
      flaga_q <= bus.flaga;
      flagb_q <= bus.flagb;
    end
  end

  // Mode request: 2-flop synchronizer followed by a stability filter
  logic [1:0]       sync1_q, sync2_q, req_mode_q;
  logic [StabW-1:0] stab_cnt_q;

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      sync1_q    <= 2'd0;
      sync2_q    <= 2'd0;
      stab_cnt_q <= '0;
      req_mode_q <= 2'd0;
    end else begin
      sync1_q <= bus.mode_sel;
      sync2_q <= sync1_q;
      // sync1 != sync2 means sync2 changes on this edge, so the hold time restarts
      if (sync1_q != sync2_q) begin
        stab_cnt_q <= '0;
      end else if (stab_cnt_q != StabW'(STABLE_CYCLES - 1)) begin
        stab_cnt_q <= stab_cnt_q + 1'b1;
      end else begin
        req_mode_q <= sync2_q;
      end
    end
  end

  // Generator mux, live only while a mode is granted or draining
  state_e            state_q;
  logic [1:0]        active_mode_q;
  logic              mux_slwr, mux_pktend;
  logic [DATA_W-1:0] mux_data;
  logic              gen_busy;

  always_comb begin
    mux_slwr   = 1'b1;
    mux_pktend = 1'b1;
    mux_data   = '0;
    if (state_q != StIdle) begin
      case (active_mode_q)
        2'd1: begin
          mux_slwr   = bus.slwr_stream_;
          mux_pktend = bus.pktend_stream_;
          mux_data   = bus.data_stream;
        end
        2'd2: begin
          mux_slwr   = bus.slwr_partial_;
          mux_pktend = bus.pktend_partial_;
          mux_data   = bus.data_partial;
        end
        2'd3: begin
          mux_slwr   = bus.slwr_zlp_;
          mux_pktend = bus.pktend_zlp_;
          mux_data   = bus.data_out_zlp;
        end
        default: ;
      endcase
    end
    gen_busy = !mux_slwr || !mux_pktend;
  end

  // Registered pin drive and traffic counters
  logic                 slwr_q, pktend_q;
  logic [DATA_W-1:0]    fdata_q;
  logic [31:0]          word_cnt_q;
  logic [PKT_CNT_W-1:0] pkt_cnt_q;

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      slwr_q     <= 1'b1;
      pktend_q   <= 1'b1;
      fdata_q    <= '0;
      word_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      slwr_q   <= mux_slwr;
      pktend_q <= mux_pktend;
      fdata_q  <= mux_data;
      if (!slwr_q) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
      if (!pktend_q) begin
        pkt_cnt_q <= pkt_cnt_q + 1'b1;
      end
    end
  end

  // Mode FSM
  logic [2:0]        sel_q;  // {zlp, partial, stream}
  logic              slcs_q, fdata_oe_q;
  logic [DrainW-1:0] drain_cnt_q;

  function automatic logic [2:0] mode_onehot(input logic [1:0] mode);
    case (mode)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      active_mode_q <= 2'd0;
      sel_q         <= 3'b000;
      slcs_q        <= 1'b1;
      fdata_oe_q    <= 1'b0;
      drain_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_mode_q != 2'd0) begin
            state_q       <= StActive;
            active_mode_q <= req_mode_q;
            sel_q         <= mode_onehot(req_mode_q);
            slcs_q        <= 1'b0;
            fdata_oe_q    <= 1'b1;
          end
        end
        StActive: begin
          if (req_mode_q != active_mode_q) begin
            state_q     <= StDrain;
            sel_q       <= 3'b000;
            drain_cnt_q <= '0;
          end
        end
        StDrain: begin
          // Any strobe from the still-muxed generator restarts the quiet interval
          if (gen_busy) begin
            drain_cnt_q <= '0;
          end else if (drain_cnt_q == DrainW'(DRAIN_CYCLES - 1)) begin
            drain_cnt_q <= '0;
            if (req_mode_q == 2'd0) begin
              state_q       <= StIdle;
              active_mode_q <= 2'd0;
              slcs_q        <= 1'b1;
              fdata_oe_q    <= 1'b0;
            end else begin
              state_q       <= StActive;
              active_mode_q <= req_mode_q;
              sel_q         <= mode_onehot(req_mode_q);
            end
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.flaga_d               = flaga_q;
  assign bus.flagb_d               = flagb_q;
  assign bus.stream_mode_selected  = sel_q[0];
  assign bus.partial_mode_selected = sel_q[1];
  assign bus.zlp_mode_selected     = sel_q[2];
  assign bus.slcs_                 = slcs_q;
  assign bus.slwr_                 = slwr_q;
  assign bus.slrd_                 = 1'b1;
  assign bus.sloe_                 = 1'b1;
  assign bus.pktend_               = pktend_q;
  assign bus.fifo_addr             = 2'b00;
  assign bus.fdata                 = fdata_q;
  assign bus.fdata_oe              = fdata_oe_q;
  assign bus.active_mode           = active_mode_q;
  assign bus.wr_word_cnt           = word_cnt_q;
  assign bus.pkt_cnt               = pkt_cnt_q;

endmodule

// File: tb/tb_slavefifo2b_bus_ctrl.sv
// Self-checking bench for slavefifo2b_bus_ctrl: directed mode sequence with random generator
// traffic and random flags, checked against a cycle-level behavioural model.
module tb_slavefifo2b_bus_ctrl;

  localparam int unsigned DataW  = 32;
  localparam int unsigned Stable = 16;
  localparam int unsigned Drain  = 32;
  localparam int unsigned PktW   = 16;

  logic clk_100 = 1'b0;
  logic reset;

  always #5 clk_100 = ~clk_100;

  slavefifo2b_bus_ctrl_if #(.DATA_W(DataW), .PKT_CNT_W(PktW)) bus ();

  slavefifo2b_bus_ctrl #(
    .DATA_W       (DataW),
    .STABLE_CYCLES(Stable),
    .DRAIN_CYCLES (Drain),
    .PKT_CNT_W    (PktW)
  ) dut (
    .clk_100(clk_100),
    .reset  (reset),
    .bus    (bus.master)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: which generator should reach the pins (0 = none) and expected counts
  bit          check_pins = 1'b0;
  logic [1:0]  pass_mode  = 2'd0;
  logic [31:0] exp_words  = '0;
  logic [15:0] exp_pkts   = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_gens();
    bus.slwr_stream_    = 1'b1;
    bus.pktend_stream_  = 1'b1;
    bus.data_stream     = '0;
    bus.slwr_partial_   = 1'b1;
    bus.pktend_partial_ = 1'b1;
    bus.data_partial    = '0;
    bus.slwr_zlp_       = 1'b1;
    bus.pktend_zlp_     = 1'b1;
    bus.data_out_zlp    = '0;
  endtask

  task automatic rand_gens(input bit zlp_quiet);
    bus.slwr_stream_    = 1'($urandom_range(0, 1));
    bus.pktend_stream_  = ($urandom_range(0, 3) != 0);
    bus.data_stream     = DataW'($urandom);
    bus.slwr_partial_   = 1'($urandom_range(0, 1));
    bus.pktend_partial_ = ($urandom_range(0, 3) != 0);
    bus.data_partial    = DataW'($urandom);
    bus.slwr_zlp_       = zlp_quiet ? 1'b1 : 1'($urandom_range(0, 1));
    bus.pktend_zlp_     = zlp_quiet ? 1'b1 : ($urandom_range(0, 3) != 0);
    bus.data_out_zlp    = DataW'($urandom);
  endtask

  // One clock: capture what the model says is being presented, clock, then compare.
  task automatic tick();
    logic s, p, fa, fb;
    logic [DataW-1:0] d;
    s  = 1'b1;
    p  = 1'b1;
    d  = '0;
    fa = bus.flaga;
    fb = bus.flagb;
    case (pass_mode)
      2'd1: begin s = bus.slwr_stream_;  p = bus.pktend_stream_;  d = bus.data_stream;  end
      2'd2: begin s = bus.slwr_partial_; p = bus.pktend_partial_; d = bus.data_partial; end
      2'd3: begin s = bus.slwr_zlp_;     p = bus.pktend_zlp_;     d = bus.data_out_zlp; end
      default: ;
    endcase
    @(posedge clk_100);
    #1;
    if (check_pins) begin
      chk("slwr_pin", bus.slwr_, s);
      chk("pktend_pin", bus.pktend_, p);
      if (pass_mode != 2'd0) chk("fdata", bus.fdata, d);
      chk("wr_word_cnt", bus.wr_word_cnt, exp_words);
      chk("pkt_cnt", bus.pkt_cnt, exp_pkts);
      if (!s) exp_words++;
      if (!p) exp_pkts++;
    end
    if (!reset) begin
      chk("flaga_d", bus.flaga_d, fa);
      chk("flagb_d", bus.flagb_d, fb);
    end
    bus.flaga = 1'($urandom_range(0, 1));
    bus.flagb = 1'($urandom_range(0, 1));
  endtask

  initial begin
    reset        = 1'b1;
    bus.mode_sel = 2'd0;
    bus.flaga    = 1'b0;
    bus.flagb    = 1'b0;
    idle_gens();
    repeat (3) @(posedge clk_100);
    #1;

    chk("rst_slwr", bus.slwr_, 1'b1);
    chk("rst_pktend", bus.pktend_, 1'b1);
    chk("rst_slrd", bus.slrd_, 1'b1);
    chk("rst_sloe", bus.sloe_, 1'b1);
    chk("rst_slcs", bus.slcs_, 1'b1);
    chk("rst_fdata", bus.fdata, 0);
    chk("rst_fdata_oe", bus.fdata_oe, 1'b0);
    chk("rst_sel", {bus.zlp_mode_selected, bus.partial_mode_selected,
                    bus.stream_mode_selected}, 3'b000);
    chk("rst_active_mode", bus.active_mode, 2'd0);
    chk("rst_words", bus.wr_word_cnt, 0);
    chk("rst_pkts", bus.pkt_cnt, 0);
    chk("rst_flags", {bus.flaga_d, bus.flagb_d}, 2'b00);
    chk("fifo_addr", bus.fifo_addr, 2'b00);

    // Request ZLP mode: 2 sync + STABLE_CYCLES hold + 1 FSM cycle
    reset        = 1'b0;
    bus.mode_sel = 2'd3;
    check_pins   = 1'b1;
    for (int k = 1; k <= 2 + Stable + 1; k++) begin
      tick();
      if (k == 2 + Stable) chk("zlp_sel_early", bus.zlp_mode_selected, 1'b0);
    end
    chk("zlp_sel", bus.zlp_mode_selected, 1'b1);
    chk("stream_sel_off", bus.stream_mode_selected, 1'b0);
    chk("act_slcs", bus.slcs_, 1'b0);
    chk("act_fdata_oe", bus.fdata_oe, 1'b1);
    chk("act_mode3", bus.active_mode, 2'd3);
    pass_mode = 2'd3;

    // Four words 0..3 from the ZLP generator
    for (int i = 0; i < 4; i++) begin
      bus.slwr_zlp_    = 1'b0;
      bus.data_out_zlp = DataW'(i);
      tick();
    end
    idle_gens();
    tick();
    chk("words4", bus.wr_word_cnt, 4);

    // Zero-length packet
    bus.pktend_zlp_ = 1'b0;
    tick();
    chk("zlp_pktend", bus.pktend_, 1'b0);
    chk("zlp_slwr_high", bus.slwr_, 1'b1);
    idle_gens();
    tick();
    chk("pkts1", bus.pkt_cnt, 1);

    // Random traffic on all generators, only ZLP may pass
    for (int i = 0; i < 30; i++) begin
      rand_gens(1'b0);
      tick();
    end

    // Short glitch on mode_sel must not change the grant
    bus.mode_sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      rand_gens(1'b0);
      tick();
    end
    bus.mode_sel = 2'd3;
    for (int i = 0; i < 25; i++) begin
      rand_gens(1'b0);
      tick();
      chk("glitch_zlp_sel", bus.zlp_mode_selected, 1'b1);
      chk("glitch_mode", bus.active_mode, 2'd3);
    end

    // Real switch to stream while ZLP keeps writing
    bus.mode_sel = 2'd1;
    for (int k = 1; k <= 2 + Stable + 1; k++) begin
      rand_gens(1'b0);
      tick();
      if (k == 2 + Stable) chk("sw_zlp_sel_held", bus.zlp_mode_selected, 1'b1);
    end
    chk("drain_zlp_sel", bus.zlp_mode_selected, 1'b0);
    chk("drain_stream_sel", bus.stream_mode_selected, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rand_gens(1'b0);
      if (i == 5) bus.slwr_zlp_ = 1'b0;
      tick();
    end
    // ZLP generator goes quiet; stream toggles but must not reach the pins
    for (int k = 1; k <= Drain; k++) begin
      rand_gens(1'b1);
      tick();
      if (k == Drain - 1) chk("drain_hold", bus.stream_mode_selected, 1'b0);
      if (k == Drain / 2) chk("drain_oe", bus.fdata_oe, 1'b1);
    end
    chk("stream_sel", bus.stream_mode_selected, 1'b1);
    chk("stream_mode", bus.active_mode, 2'd1);
    chk("stream_zlp_off", bus.zlp_mode_selected, 1'b0);
    pass_mode = 2'd1;

    for (int i = 0; i < 20; i++) begin
      rand_gens(1'b0);
      tick();
    end

    // Reset in the middle of a burst acts without a clock edge
    bus.slwr_stream_ = 1'b0;
    tick();
    tick();
    chk("pre_rst_slwr", bus.slwr_, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_slwr", bus.slwr_, 1'b1);
    chk("mid_rst_pktend", bus.pktend_, 1'b1);
    chk("mid_rst_words", bus.wr_word_cnt, 0);
    chk("mid_rst_pkts", bus.pkt_cnt, 0);
    chk("mid_rst_oe", bus.fdata_oe, 1'b0);
    chk("mid_rst_slcs", bus.slcs_, 1'b1);
    chk("mid_rst_sel", bus.stream_mode_selected, 1'b0);
    chk("mid_rst_mode", bus.active_mode, 2'd0);
    chk("mid_rst_fdata", bus.fdata, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
